// File: rtl/w_stage_grf.sv
// Write-back stage and 32x32 general register file for the five-stage MIPS pipeline.
// Selects/extends the write-back value, commits it, and serves two bypassed read ports.
module w_stage_grf #(
  parameter logic [31:0] LINK_OFFSET = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] W_PC,
  input  logic [31:0] W_Instr,
  input  logic [4:0]  W_for_GRFWriteAddr,
  input  logic [31:0] W_ALUResult,
  input  logic [31:0] W_RD,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  output logic [31:0] D_rs_data,
  output logic [31:0] D_rt_data,
  output logic [31:0] W_wdata,
  output logic        trace_we,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_addr,
  output logic [31:0] trace_data
);

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] FN_JALR    = 6'h09;

  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic [1:0]    off;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [DW-1:0] link_addr;
  logic [DW-1:0] wdata;
  logic          we;
  logic          unused_instr;

  assign opcode       = W_Instr[31:26];
  assign funct        = W_Instr[5:0];
  assign off          = W_ALUResult[1:0];
  assign link_addr    = W_PC + LINK_OFFSET;
  assign unused_instr = ^W_Instr[25:6];
  assign we           = (W_for_GRFWriteAddr != AW'(0)) && !reset;

  // Write-back source select and load extension
  always_comb begin
    ld_byte = '0;
    ld_half = off[1] ? W_RD[31:16] : W_RD[15:0];
    wdata   = W_ALUResult;
    case (off)
      2'd0:    ld_byte = W_RD[7:0];
      2'd1:    ld_byte = W_RD[15:8];
      2'd2:    ld_byte = W_RD[23:16];
      default: ld_byte = W_RD[31:24];
    endcase
    case (opcode)
      OP_LW:      wdata = W_RD;
      OP_LB:      wdata = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:     wdata = {24'b0, ld_byte};
      OP_LH:      wdata = {{16{ld_half[15]}}, ld_half};
      OP_LHU:     wdata = {16'b0, ld_half};
      OP_JAL:     wdata = link_addr;
      OP_SPECIAL: if (funct == FN_JALR) wdata = link_addr;
      default:    ;
    endcase
  end

  assign W_wdata = wdata;

  // Storage for $1..$31; $0 is implied zero
  logic [DW-1:0] regs [1:NREG-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < int'(NREG); i++) regs[i] <= '0;
    end else if (we) begin
      for (int i = 1; i < int'(NREG); i++)
        if (W_for_GRFWriteAddr == AW'(i)) regs[i] <= wdata;
    end
  end

  logic [DW-1:0] rs_store;
  logic [DW-1:0] rt_store;

  always_comb begin
    rs_store = '0;
    rt_store = '0;
    for (int i = 1; i < int'(NREG); i++) begin
      if (D_rs_addr == AW'(i)) rs_store = regs[i];
      if (D_rt_addr == AW'(i)) rt_store = regs[i];
    end
  end

  // Zero register, then same-cycle write-through, then storage
  assign D_rs_data = (D_rs_addr == AW'(0)) ? '0 :
                     (we && D_rs_addr == W_for_GRFWriteAddr) ? wdata : rs_store;
  assign D_rt_data = (D_rt_addr == AW'(0)) ? '0 :
                     (we && D_rt_addr == W_for_GRFWriteAddr) ? wdata : rt_store;

  assign trace_we   = we;
  assign trace_pc   = W_PC;
  assign trace_addr = W_for_GRFWriteAddr;
  assign trace_data = wdata;

endmodule
